// File: rtl/adc_sample_fifo.sv
// adc_sample_fifo
//   Buffers ADC conversion results so the MCU can drain them over the EBI in
//   bursts. Samples enter from the ADC controller; the MCU reads them through
//   a small register window at EBI word address POSITION.
//
//   Register window (offsets from POSITION):
//     +0 DATA    (R) head sample; a completed read pops it (no pop when empty)
//     +1 COUNT   (R) occupancy 0..2^DEPTH_LOG2, zero-extended
//     +2 STATUS  (R) {capture_en, overflow, full, empty} in bits [3:0]
//     +3 CONTROL (W) bit0 flush, bit1 clear overflow (both self-clearing),
//                    bit2 capture_en; reads return 0
//     +4 DECIM   (R/W) only when ADC_SAMPLE_FIFO_DECIM_EN is defined
//
//   Optional feature macro: ADC_SAMPLE_FIFO_DECIM_EN (decimation register).
//
//   Ports:
//     clk          sys_clk
//     reset        asynchronous, active-low
//     enable       EBI chip select (active-high)
//     addr[18:0]   EBI word address
//     data_wr      EBI write strobe (active-high)
//     data_rd      EBI read strobe (active-high)
//     data_in      EBI write data
//     data_out     read data for the wired-OR bus, 0 when not addressed
//     sample_valid one-cycle pulse qualifying sample_data
//     sample_data  ADC sample
//     overflow     sticky overflow flag
//
//   EBI handshake: the bus has no valid/ready; an access is the interval in
//   which enable&strobe is high. Both strobes are brought into clk through a
//   2-flop synchronizer. addr/data_in are captured on the synchronized rising
//   edge; register writes act one cycle later; a DATA read pops on the
//   synchronized falling edge. Read data itself is driven combinationally from
//   the live address for the whole access.

module adc_sample_fifo #(
  parameter int POSITION   = 110,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [18:0] addr,
  input  logic        data_wr,
  input  logic        data_rd,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  input  logic        sample_valid,
  input  logic [15:0] sample_data,
  output logic        overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [18:0] A_DATA   = 19'(POSITION);
  localparam logic [18:0] A_COUNT  = 19'(POSITION + 1);
  localparam logic [18:0] A_STATUS = 19'(POSITION + 2);
  localparam logic [18:0] A_CTRL   = 19'(POSITION + 3);
  localparam logic [DEPTH_LOG2:0] PTR_ONE = (DEPTH_LOG2 + 1)'(1);

`ifdef ADC_SAMPLE_FIFO_DECIM_EN
  localparam logic [18:0] A_DECIM = 19'(POSITION + 4);
  localparam int WR_BITS = 8;
`else
  localparam int WR_BITS = 3;
`endif

  // Strobe synchronizers; bit [2] is the delayed copy used for edge detect.
  logic [2:0] rd_sync;
  logic [2:0] wr_sync;
  logic       rd_rise, rd_fall, wr_rise;

  logic               rd_data_q;   // captured: this read targets DATA
  logic               wr_pend;     // captured write is applied this cycle
  logic [18:0]        wr_addr_q;
  logic [WR_BITS-1:0] wr_data_q;

  logic [15:0]           mem [DEPTH];
  logic [DEPTH_LOG2:0]   wptr, rptr, count;
  logic                  full, empty;
  logic                  capture_en;
  logic                  ctrl_wr, flush, ovf_clr;
  logic                  pop, push_req, push_ok, ovf_set;
  logic                  decim_hit;
  logic [15:0]           rd_mux;

  // data_in upper bits are not stored by any register.
  logic unused_data_in;
  assign unused_data_in = &{1'b0, data_in[15:WR_BITS]};

  assign rd_rise = rd_sync[1] & ~rd_sync[2];
  assign rd_fall = ~rd_sync[1] & rd_sync[2];
  assign wr_rise = wr_sync[1] & ~wr_sync[2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_sync   <= '0;
      wr_sync   <= '0;
      rd_data_q <= 1'b0;
      wr_pend   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      rd_sync <= {rd_sync[1:0], enable & data_rd};
      wr_sync <= {wr_sync[1:0], enable & data_wr};
      wr_pend <= wr_rise;
      if (rd_rise) rd_data_q <= (addr == A_DATA);
      if (wr_rise) begin
        wr_addr_q <= addr;
        wr_data_q <= data_in[WR_BITS-1:0];
      end
    end
  end

  assign ctrl_wr = wr_pend && (wr_addr_q == A_CTRL);
  assign flush   = ctrl_wr & wr_data_q[0];
  assign ovf_clr = ctrl_wr & wr_data_q[1];

  assign full  = (wptr[DEPTH_LOG2] != rptr[DEPTH_LOG2]) &&
                 (wptr[DEPTH_LOG2-1:0] == rptr[DEPTH_LOG2-1:0]);
  assign empty = (wptr == rptr);
  assign count = wptr - rptr;

  // Popping when empty is impossible, so an empty FIFO sees the push only.
  // A full FIFO accepts a push only when a pop frees the head slot in the
  // same cycle. Flush discards any coincident sample.
  assign pop      = rd_fall & rd_data_q & ~empty;
  assign push_req = sample_valid & capture_en & decim_hit;
  assign push_ok  = push_req & (~full | pop) & ~flush;
  assign ovf_set  = push_req & full & ~pop & ~flush;

`ifdef ADC_SAMPLE_FIFO_DECIM_EN
  logic [7:0] decim, dec_cnt;
  logic       decim_wr;

  assign decim_wr  = wr_pend && (wr_addr_q == A_DECIM);
  assign decim_hit = (dec_cnt == decim);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      decim   <= '0;
      dec_cnt <= '0;
    end else begin
      if (decim_wr) decim <= wr_data_q[7:0];
      if (flush || decim_wr) dec_cnt <= '0;
      else if (sample_valid && capture_en) dec_cnt <= decim_hit ? 8'd0 : dec_cnt + 8'd1;
    end
  end
`else
  assign decim_hit = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr       <= '0;
      rptr       <= '0;
      capture_en <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (push_ok) wptr <= wptr + PTR_ONE;
        if (pop)     rptr <= rptr + PTR_ONE;
      end
      if (ctrl_wr) capture_en <= wr_data_q[2];
      // Set has priority over a clear landing in the same cycle.
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // Storage has no reset; occupancy is defined solely by the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[DEPTH_LOG2-1:0]] <= sample_data;
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      A_DATA:   rd_mux = empty ? 16'h0000 : mem[rptr[DEPTH_LOG2-1:0]];
      A_COUNT:  rd_mux = 16'(count);
      A_STATUS: rd_mux = {12'h000, capture_en, overflow, full, empty};
`ifdef ADC_SAMPLE_FIFO_DECIM_EN
      A_DECIM:  rd_mux = {8'h00, decim};
`endif
      default:  rd_mux = '0;
    endcase
  end

  // Gated by reset so the bus is released immediately when reset asserts.
  assign data_out = (reset && enable && data_rd) ? rd_mux : 16'h0000;

endmodule
